// File: rtl/flex_stp_deser.sv
// Serial-to-parallel deserializer with framing, held output word, valid/ready handshake and overrun flag.
// Optional even-parity check is compiled in with the STP_PARITY_EN macro.
module flex_stp_deser #(
    parameter int NUM_BITS  = 4,
    parameter int SHIFT_MSB = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            serial_in,
    input  logic                            shift_enable,
    input  logic                            frame_sync,
    input  logic                            data_ready,
    output logic [NUM_BITS-1:0]             data_out,
    output logic                            data_valid,
    output logic                            overrun,
    output logic                            parity_err,
    output logic [$clog2(NUM_BITS+2)-1:0]   bit_count
);

    localparam int CW = $clog2(NUM_BITS+2);
`ifdef STP_PARITY_EN
    localparam int WORD_LEN = NUM_BITS + 1;
`else
    localparam int WORD_LEN = NUM_BITS;
`endif
    localparam logic [CW-1:0] LAST_CNT = CW'(WORD_LEN - 1);

    logic [NUM_BITS-1:0] sr;
    logic [NUM_BITS-1:0] sr_base;
    logic [NUM_BITS-1:0] sr_shifted;
    logic [NUM_BITS-1:0] word;
    logic                sr_load;
    logic                complete;
    logic                xfer;

    // Handshake: data_out is offered while data_valid=1; a word moves to the
    // consumer on every edge where data_valid and data_ready are both high.
    assign xfer     = data_valid & data_ready;
    assign complete = shift_enable & ~frame_sync & (bit_count == LAST_CNT);

    // A sync with an accepted bit starts the new word from an idle (all ones) register.
    always_comb begin
        sr_base = frame_sync ? '1 : sr;
        if (SHIFT_MSB != 0) begin
            sr_shifted = {sr_base[NUM_BITS-2:0], serial_in};
        end else begin
            sr_shifted = {serial_in, sr_base[NUM_BITS-1:1]};
        end
    end

`ifdef STP_PARITY_EN
    // The trailing parity bit is never shifted in, so the data bits stay in sr.
    assign sr_load = shift_enable & (frame_sync | (bit_count < CW'(NUM_BITS)));
    assign word    = sr;
`else
    assign sr_load = shift_enable;
    assign word    = sr_shifted;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '1;
        end else if (sr_load) begin
            sr <= sr_shifted;
        end else if (frame_sync && !shift_enable) begin
            sr <= '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_count <= '0;
        end else if (shift_enable) begin
            if (frame_sync) begin
                bit_count <= CW'(1);
            end else if (complete) begin
                bit_count <= '0;
            end else begin
                bit_count <= bit_count + CW'(1);
            end
        end else if (frame_sync) begin
            bit_count <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '1;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete && (!data_valid || data_ready)) begin
                data_out   <= word;
                data_valid <= 1'b1;
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (xfer) begin
                data_valid <= 1'b0;
            end
        end
    end

`ifdef STP_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (complete && (!data_valid || data_ready)) begin
            parity_err <= (^sr) ^ serial_in;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_flex_stp_deser.sv
// Directed bench for flex_stp_deser: MSB-first and LSB-first instances share one stimulus stream.
// Honours STP_PARITY_EN when defined (parity bit appended to every word).
module tb_flex_stp_deser;

    localparam int NB = 8;
    localparam int CW = $clog2(NB+2);

    logic          clk;
    logic          rst;
    logic          serial_in;
    logic          shift_enable;
    logic          frame_sync;
    logic          data_ready;
    logic [NB-1:0] m_data, l_data;
    logic          m_valid, l_valid;
    logic          m_ovr, l_ovr;
    logic          m_perr, l_perr;
    logic [CW-1:0] m_cnt, l_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    flex_stp_deser #(.NUM_BITS(NB), .SHIFT_MSB(1)) u_msb (
        .clk(clk), .rst(rst), .serial_in(serial_in), .shift_enable(shift_enable),
        .frame_sync(frame_sync), .data_ready(data_ready), .data_out(m_data),
        .data_valid(m_valid), .overrun(m_ovr), .parity_err(m_perr), .bit_count(m_cnt)
    );

    flex_stp_deser #(.NUM_BITS(NB), .SHIFT_MSB(0)) u_lsb (
        .clk(clk), .rst(rst), .serial_in(serial_in), .shift_enable(shift_enable),
        .frame_sync(frame_sync), .data_ready(data_ready), .data_out(l_data),
        .data_valid(l_valid), .overrun(l_ovr), .parity_err(l_perr), .bit_count(l_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_in    = b;
        shift_enable = 1'b1;
        @(posedge clk);
        #1;
        shift_enable = 1'b0;
    endtask

    // Sends w bit7 first; data_ready takes rdy_last before the final bit of the word.
    task automatic send_word(input logic [7:0] w, input logic rdy_last, input logic flip_par);
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
`ifdef STP_PARITY_EN
        send_bit(w[0]);
        data_ready = rdy_last;
        send_bit((^w) ^ flip_par);
`else
        data_ready = rdy_last;
        send_bit(w[0]);
        if (flip_par) send_bit(1'b1);
`endif
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_mdata"}, m_data, 32'hFF);
        check({tag, "_ldata"}, l_data, 32'hFF);
        check({tag, "_valid"}, {m_valid, l_valid}, 0);
        check({tag, "_ovr"}, {m_ovr, l_ovr}, 0);
        check({tag, "_perr"}, {m_perr, l_perr}, 0);
        check({tag, "_cnt"}, {m_cnt, l_cnt}, 0);
    endtask

    initial begin
        logic [7:0] w;
        rst = 1'b1; serial_in = 1'b1; shift_enable = 1'b0; frame_sync = 1'b0; data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        idle();

        // Basic word with consumer ready
        send_word(8'hB2, 1'b1, 1'b0);
        check("w1_mdata", m_data, 32'hB2);
        check("w1_ldata", l_data, 32'h4D);
        check("w1_valid", {m_valid, l_valid}, 2'b11);
        check("w1_cnt", m_cnt, 0);
        check("w1_perr", m_perr, 0);
        idle();
        check("w1_valid_clr", {m_valid, l_valid}, 2'b00);

        // Gapped shift_enable, every 3rd cycle
        w = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            check("gap_cnt", m_cnt, i);
            send_bit(w[7-i]);
            idle();
            idle();
        end
`ifdef STP_PARITY_EN
        check("gap_cnt_par", m_cnt, 8);
        send_bit(1'b0);
`endif
        check("gap_mdata", m_data, 32'hB2);
        check("gap_ldata", l_data, 32'h4D);
        idle();

        // Overrun: consumer stalled across two words
        data_ready = 1'b0;
        send_word(8'hB2, 1'b0, 1'b0);
        check("ovr_first_valid", m_valid, 1);
        check("ovr_first_ovr", m_ovr, 0);
        send_word(8'h4D, 1'b0, 1'b0);
        check("ovr_pulse", {m_ovr, l_ovr}, 2'b11);
        check("ovr_mdata_held", m_data, 32'hB2);
        check("ovr_ldata_held", l_data, 32'h4D);
        check("ovr_valid_held", {m_valid, l_valid}, 2'b11);
        idle();
        check("ovr_pulse_end", {m_ovr, l_ovr}, 2'b00);
        data_ready = 1'b1;
        idle();
        check("ovr_valid_clr", m_valid, 0);

        // Completion coincident with a transfer: valid stays high, data replaced
        data_ready = 1'b0;
        send_word(8'hB2, 1'b0, 1'b0);
        send_word(8'h4D, 1'b1, 1'b0);
        check("sim_valid", m_valid, 1);
        check("sim_mdata", m_data, 32'h4D);
        check("sim_ldata", l_data, 32'hB2);
        check("sim_ovr", m_ovr, 0);
        idle();
        check("sim_valid_clr", m_valid, 0);

        // frame_sync alone realigns to an empty word
        send_bit(1'b0);
        send_bit(1'b0);
        frame_sync = 1'b1;
        idle();
        frame_sync = 1'b0;
        check("fs_alone_cnt", m_cnt, 0);

        // frame_sync with shift_enable: current bit starts the word
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        check("fs_pre_cnt", m_cnt, 3);
        frame_sync = 1'b1;
        send_bit(1'b1);
        frame_sync = 1'b0;
        check("fs_cnt", m_cnt, 1);
        check("fs_no_valid", m_valid, 0);
        w = 8'hB2;
        for (int i = 6; i >= 0; i--) send_bit(w[i]);
`ifdef STP_PARITY_EN
        send_bit(1'b0);
`endif
        check("fs_mdata", m_data, 32'hB2);
        check("fs_ldata", l_data, 32'h4D);
        check("fs_valid", m_valid, 1);
        idle();

        // Asynchronous reset mid-word with a held word pending
        data_ready = 1'b0;
        send_word(8'h4D, 1'b0, 1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        #2 rst = 1'b1;
        #1;
        check_reset("midrst");
        idle();
        rst = 1'b0;
        data_ready = 1'b1;
        idle();
        send_word(8'h4D, 1'b1, 1'b0);
        check("post_rst_mdata", m_data, 32'h4D);
        check("post_rst_ldata", l_data, 32'hB2);
        idle();

        // Parity bit handling
        send_word(8'hB2, 1'b1, 1'b1);
`ifdef STP_PARITY_EN
        check("par_bad_perr", {m_perr, l_perr}, 2'b11);
        check("par_bad_mdata", m_data, 32'hB2);
        idle();
        send_word(8'hB2, 1'b1, 1'b0);
        check("par_good_perr", {m_perr, l_perr}, 2'b00);
`else
        check("nopar_cnt", {m_cnt, l_cnt}, {4'd1, 4'd1});
        check("nopar_perr", {m_perr, l_perr}, 2'b00);
        check("nopar_valid", m_valid, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flex_stp_deser.md
# flex_stp_deser

Parametrised serial-to-parallel deserializer built on the flex shift-register core. It adds framing, an output holding register, a valid/ready handshake toward the consumer and an overrun flag. A bit counter tracks progress through each word, and an optional parity check is compiled in by macro. It sits between a serial bit source (e.g. a UART/SPI receive front end) and a word-wide consumer.

## Interface
Parameters:
- NUM_BITS, 4: data word width, 2 to 32.
- SHIFT_MSB, 1: 1 = shift toward MSB, so the first bit received lands in the MSB. 0 = shift toward LSB, so the first bit received lands in bit 0.

Ports (direction, width, meaning):
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- serial_in, in, 1: serial data bit, sampled when shift_enable=1.
- shift_enable, in, 1: accept serial_in on this edge.
- frame_sync, in, 1: synchronous word-boundary realign.
- data_ready, in, 1: consumer accepts data_out.
- data_out, out, NUM_BITS: completed word, held while data_valid=1.
- data_valid, out, 1: data_out holds an unconsumed word.
- overrun, out, 1: one-cycle pulse when a completed word is dropped.
- parity_err, out, 1: parity result for the current data_out. Constant 0 without the macro.
- bit_count, out, $clog2(NUM_BITS+2): bits received in the current word.

## Operation
Reset values:
- Shift register and data_out: all ones (idle line).
- data_valid, overrun, parity_err, bit_count: 0.

Shift register:
- Updates only on edges where shift_enable=1.
- SHIFT_MSB=1: {sr[NUM_BITS-2:0], serial_in}.
- SHIFT_MSB=0: {serial_in, sr[NUM_BITS-1:1]}.

Bit counter:
- Increments on each accepted bit.
- The word completes on the accepted bit that brings bit_count to WORD_LEN. WORD_LEN = NUM_BITS, or NUM_BITS+1 with parity.
- On completion bit_count returns to 0 on that same edge. The shift register is not cleared.

Handshake:
- A transfer occurs on any edge where data_valid=1 and data_ready=1.
- On completion with data_valid=0, or with a transfer on the same edge: data_out is loaded with the completed word (including the final bit), and data_valid=1 after that edge.
- On completion with data_valid=1 and data_ready=0: the held word is kept, the new word is discarded, and overrun=1 for exactly the next cycle.
- A transfer with no completion clears data_valid after the edge.

frame_sync:
- Asserted without shift_enable: bit_count goes to 0 and the shift register goes to all ones.
- Asserted with shift_enable: the current bit is taken as the first bit of the new word, and bit_count=1.
- Does not affect data_out, data_valid or overrun.

Reset mid-word or mid-handshake: everything returns immediately to its reset value and the partial word is lost.

## Timing
- Latency: data_out and data_valid are visible on the clock edge that accepts the last bit of the word (registered outputs, zero additional cycles).
- Back-to-back: with data_ready held at 1, one word per WORD_LEN enabled cycles, with no bubble.
- A simultaneous completion and transfer keeps data_valid at 1 continuously, with data_out updated to the new word.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- STP_PARITY_EN defined:
  - WORD_LEN = NUM_BITS+1. The extra bit is an even-parity bit received after the data bits.
  - The parity bit is not stored in data_out.
  - parity_err = XOR of the data bits and the parity bit. It is loaded together with data_out and reset to 0.
- STP_PARITY_EN undefined: WORD_LEN = NUM_BITS and parity_err is tied to 0.

## Test plan
- NUM_BITS=8, SHIFT_MSB=1, data_ready=1, serial 1,0,1,1,0,0,1,0 -> data_out=8'hB2 and data_valid=1 on the 8th enabled edge, then 0 the following cycle.
- NUM_BITS=8, SHIFT_MSB=0, same bits -> data_out=8'h4D. Gapped shift_enable (every 3rd cycle) gives the same result and bit_count steps 0..7.
- data_ready=0, send 8'hB2 then 8'h4D -> data_out stays 8'hB2, data_valid stays 1, overrun pulses once. Raising data_ready clears data_valid.
- Send 3 bits, then frame_sync together with shift_enable, then 7 more bits 1,0,1,1,0,0,1,0 total -> single word 8'hB2 with bit_count=1 after the sync edge. Assert rst mid-word -> all outputs at reset values and the next full word decodes correctly.
- STP_PARITY_EN, NUM_BITS=8: 8'hB2 + parity 0 -> parity_err=0. 8'hB2 + parity 1 -> parity_err=1. Without the macro, the 9th bit starts a new word.
